food_map_arbiter: RTL and testbench
===================================

# food_map_arbiter

Controller that owns the single port of the `food_map` block RAM (one 80-bit row per maze row, one bit per pellet) and shares it between two requesters. The requesters are the renderer, which reads whole rows, and the pacman eat logic, which clears one pellet bit by read-modify-write. The block sequences each access through an FSM and arbitrates round-robin. It reports whether each eat found a pellet, and optionally keeps an eaten-pellet tally and an all-eaten flag for the game-state logic.

## Interface
Parameters:
- `ROWS`, 60: number of map rows; valid `y` range is 0..ROWS-1.
- `COLS`, 80: bits per row; valid `x` range is 0..COLS-1.
- `TOTAL_FOOD`, 1000: pellet count that asserts `all_eaten`.

Ports:
- `clk` input 1: the single clock; all logic is on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `rd_req` input 1: renderer row-read request; held until `rd_valid`.
- `rd_row` input 6: row to read; must be stable while `rd_req` is high.
- `rd_valid` output 1: one-cycle pulse; `rd_data` is valid during it.
- `rd_data` output 80: registered row contents.
- `eat_req` input 1: eat request; held until `eat_ack`.
- `eat_x` input 7: pellet column (matrix index).
- `eat_y` input 6: pellet row (matrix index).
- `eat_ack` output 1: one-cycle pulse when the eat completes.
- `eat_hit` output 1: valid with `eat_ack`; 1 means the bit was set and has now been cleared.
- `bram_en` output 1: RAM enable.
- `bram_we` output 1: RAM write enable.
- `bram_addr` output 6: RAM row address.
- `bram_din` output 80: RAM write data.
- `bram_dout` input 80: RAM read data, valid one clock after the address is sampled.
- `eaten_count` output 11: pellets eaten, saturating at TOTAL_FOOD (present when FOOD_COUNT_EN is defined).
- `all_eaten` output 1: sticky flag, set when `eaten_count` equals TOTAL_FOOD.

## Operation
- FSM states: IDLE, D_RD, D_CAP, E_RD, E_CAP, E_WR.
- All `bram_*` outputs are registered.
- Arbitration happens only in IDLE:
  - If exactly one request is pending, that request is granted.
  - If both are pending, the requester not granted last time wins. A `last_grant` bit records the last winner and resets to "eat", so the renderer wins the first tie.
- Renderer read path:
  - IDLE → D_RD: drive `bram_en`=1, `bram_we`=0, `bram_addr`=`rd_row`.
  - D_RD → D_CAP: no action while the RAM performs the read.
  - D_CAP → IDLE: `rd_data` ← `bram_dout`, pulse `rd_valid`.
- Eat path:
  - IDLE → E_RD: latch `eat_x` and `eat_y`, drive a read of row `eat_y`.
  - E_RD → E_CAP: no action while the RAM performs the read.
  - E_CAP → E_WR: capture the row and evaluate `hit` = `row[eat_x]`. If `hit` is 1, drive `bram_we`=1, `bram_din`=row with bit `eat_x` cleared, `bram_addr`=`eat_y`. If `hit` is 0, drive no write.
  - E_WR → IDLE: deassert `bram_en` and `bram_we`, pulse `eat_ack` with `eat_hit`=`hit`.
- Out-of-range coordinates (`eat_x`≥COLS or `eat_y`≥ROWS) follow the full sequence with no RAM access and no write, and are acknowledged with `eat_hit`=0.
- `bram_en` and `bram_we` are 0 in every state not listed above.

## Timing
- Read: grant at edge N; `rd_valid` is high in the cycle following edge N+2 (latency 2); at most one read per 3 cycles.
- Eat: grant at edge N; the RAM writes at edge N+3; `eat_ack` is high in the cycle following edge N+3 (latency 3).
- Consecutive eats to the same cell: the second eat reads after the first write has completed, so it returns `eat_hit`=0.
- A request deasserted before its acknowledge is undefined use; the block still completes the granted operation.
- Reset values: FSM=IDLE; `rd_valid`, `eat_ack`, `eat_hit`, `bram_en`, `bram_we`=0; `bram_addr`=0; `bram_din`, `rd_data`=0; `eaten_count`=0; `all_eaten`=0; `last_grant`=eat.
- Reset asserted mid-operation: `bram_we` drops immediately (asynchronously). An eat aborted before E_WR leaves the RAM row unchanged. No acknowledge is issued.

## Configuration
- `FOOD_COUNT_EN` defined:
  - `eaten_count` increments on each `eat_ack` with `eat_hit`=1 and saturates at TOTAL_FOOD.
  - `all_eaten` goes high in the cycle after the increment that reaches TOTAL_FOOD and stays high until reset.
- `FOOD_COUNT_EN` undefined: no counter logic is built; `eaten_count` is tied to 0 and `all_eaten` is tied to 0.

## Test plan
- Renderer read: preload row 5 = 80'h1; `rd_req`=1 with `rd_row`=5 → `rd_valid` pulses 2 cycles after the grant edge with `rd_data`=80'h1; exactly one `bram_en` cycle and no `bram_we`.
- Eat hit: row 3 = all ones; eat (x=10, y=3) → `eat_ack` with `eat_hit`=1; a subsequent read of row 3 returns all ones except bit 10.
- Eat miss and out-of-range:
  - Repeat the eat at (10, 3) → `eat_hit`=0 and no `bram_we`.
  - Eat (x=90, y=3) → `eat_hit`=0 and no RAM access.
- Contention: hold `rd_req` and `eat_req` continuously → grants alternate read, eat, read, …; neither requester waits more than one competing operation.
- Counter (FOOD_COUNT_EN, TOTAL_FOOD=2): two hits → `eaten_count`=2 and `all_eaten`=1; a third hit elsewhere leaves `eaten_count`=2.
- Reset during E_CAP: assert `rst_n`=0 → `bram_we`=0 immediately, the target row is unchanged, all outputs take their reset values, and no `eat_ack` is issued.

Source files
------------

// File: rtl/food_map_arbiter_if.sv
// ============================================================================
// Module   : food_map_arbiter_if
// Purpose  : Bundles the renderer, eat and block-RAM signals of the food map
//            arbiter. The arbiter connects through the slave modport; the
//            requesters and the RAM model connect through the master modport.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface food_map_arbiter_if #(
  parameter int COLS = 80
);
  // Renderer row-read handshake
  logic            rd_req;
  logic [5:0]      rd_row;
  logic            rd_valid;
  logic [COLS-1:0] rd_data;

  // Pacman eat handshake
  logic            eat_req;
  logic [6:0]      eat_x;
  logic [5:0]      eat_y;
  logic            eat_ack;
  logic            eat_hit;

  // Single-port block RAM
  logic            bram_en;
  logic            bram_we;
  logic [5:0]      bram_addr;
  logic [COLS-1:0] bram_din;
  logic [COLS-1:0] bram_dout;

  // Eaten-pellet tally for the game-state logic
  logic [10:0]     eaten_count;
  logic            all_eaten;

  modport slave (
    input  rd_req, rd_row, eat_req, eat_x, eat_y, bram_dout,
    output rd_valid, rd_data, eat_ack, eat_hit,
    output bram_en, bram_we, bram_addr, bram_din,
    output eaten_count, all_eaten
  );

  modport master (
    output rd_req, rd_row, eat_req, eat_x, eat_y, bram_dout,
    input  rd_valid, rd_data, eat_ack, eat_hit,
    input  bram_en, bram_we, bram_addr, bram_din,
    input  eaten_count, all_eaten
  );
endinterface

`default_nettype wire

// File: rtl/food_map.sv


// File: rtl/food_map_arbiter.sv
// ============================================================================
// Module   : food_map_arbiter
// Purpose  : Owns the single port of the food_map block RAM (one COLS-bit row
//            per maze row) and shares it round-robin between the renderer
//            (whole-row reads) and the pacman eat logic (read-modify-write
//            clear of one pellet bit).
// Options  : FOOD_COUNT_EN - when defined, builds the saturating eaten-pellet
//            counter and the sticky all_eaten flag; otherwise both are tied 0.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module food_map_arbiter #(
  parameter int ROWS       = 60,
  parameter int COLS       = 80,
  parameter int TOTAL_FOOD = 1000
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  food_map_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    D_RD  = 3'd1,
    D_CAP = 3'd2,
    E_RD  = 3'd3,
    E_CAP = 3'd4,
    E_WR  = 3'd5
  } state_t;

  localparam logic            c_grant_rd  = 1'b0;
  localparam logic            c_grant_eat = 1'b1;
  localparam logic [6:0]      c_cols      = 7'(COLS);
  localparam logic [5:0]      c_rows      = 6'(ROWS);
  localparam logic [COLS-1:0] c_one       = {{(COLS-1){1'b0}}, 1'b1};

  state_t          r_state;
  logic            r_last_grant;
  logic [6:0]      r_eat_x;
  logic [5:0]      r_eat_y;
  logic            r_oor;
  logic            r_hit;
  logic            r_rd_valid;
  logic [COLS-1:0] r_rd_data;
  logic            r_eat_ack;
  logic            r_eat_hit;
  logic            r_bram_en;
  logic            r_bram_we;
  logic [5:0]      r_bram_addr;
  logic [COLS-1:0] r_bram_din;

  logic            w_eat_in_range;
  logic            w_grant_rd;
  logic            w_grant_eat;
  logic [COLS-1:0] w_bit_mask;
  logic            w_row_hit;

  // Out-of-range eats still walk the whole sequence but never touch the RAM.
  assign w_eat_in_range = (bus.eat_x < c_cols) && (bus.eat_y < c_rows);

  // On a tie the renderer wins unless it was the last one served.
  assign w_grant_rd  = bus.rd_req && (!bus.eat_req || (r_last_grant == c_grant_eat));
  assign w_grant_eat = bus.eat_req && !w_grant_rd;

  // One-hot pellet mask for the latched column; zero when the column is beyond the row.
  assign w_bit_mask = c_one << r_eat_x;
  assign w_row_hit  = |(bus.bram_dout & w_bit_mask);

  // Access sequencer: arbitration in IDLE, then the read or read-modify-write steps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_last_grant <= c_grant_eat;
      r_eat_x      <= '0;
      r_eat_y      <= '0;
      r_oor        <= 1'b0;
      r_hit        <= 1'b0;
      r_rd_valid   <= 1'b0;
      r_rd_data    <= '0;
      r_eat_ack    <= 1'b0;
      r_eat_hit    <= 1'b0;
      r_bram_en    <= 1'b0;
      r_bram_we    <= 1'b0;
      r_bram_addr  <= '0;
      r_bram_din   <= '0;
    end else begin
      r_rd_valid <= 1'b0;
      r_eat_ack  <= 1'b0;
      case (r_state)
        IDLE: begin
          r_bram_en <= 1'b0;
          r_bram_we <= 1'b0;
          if (w_grant_rd) begin
            r_state      <= D_RD;
            r_last_grant <= c_grant_rd;
            r_bram_en    <= 1'b1;
            r_bram_addr  <= bus.rd_row;
          end else if (w_grant_eat) begin
            r_state      <= E_RD;
            r_last_grant <= c_grant_eat;
            r_eat_x      <= bus.eat_x;
            r_eat_y      <= bus.eat_y;
            r_oor        <= !w_eat_in_range;
            r_bram_en    <= w_eat_in_range;
            r_bram_addr  <= bus.eat_y;
          end
        end
        D_RD: begin
          r_bram_en <= 1'b0;
          r_state   <= D_CAP;
        end
        D_CAP: begin
          r_rd_data  <= bus.bram_dout;
          r_rd_valid <= 1'b1;
          r_state    <= IDLE;
        end
        E_RD: begin
          r_bram_en <= 1'b0;
          r_state   <= E_CAP;
        end
        E_CAP: begin
          // Write back only when a pellet was actually there.
          r_hit       <= w_row_hit && !r_oor;
          r_bram_en   <= w_row_hit && !r_oor;
          r_bram_we   <= w_row_hit && !r_oor;
          r_bram_addr <= r_eat_y;
          if (w_row_hit && !r_oor) begin
            r_bram_din <= bus.bram_dout & ~w_bit_mask;
          end
          r_state <= E_WR;
        end
        E_WR: begin
          r_bram_en <= 1'b0;
          r_bram_we <= 1'b0;
          r_eat_ack <= 1'b1;
          r_eat_hit <= r_hit;
          r_state   <= IDLE;
        end
        default: begin
          r_bram_en <= 1'b0;
          r_bram_we <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.rd_valid  = r_rd_valid;
  assign bus.rd_data   = r_rd_data;
  assign bus.eat_ack   = r_eat_ack;
  assign bus.eat_hit   = r_eat_hit;
  assign bus.bram_en   = r_bram_en;
  assign bus.bram_we   = r_bram_we;
  assign bus.bram_addr = r_bram_addr;
  assign bus.bram_din  = r_bram_din;

  // The tally is 11 bits wide; a target outside 1..2047 is not meaningful and
  // leaves an empty marker block in the elaborated hierarchy.
  if (TOTAL_FOOD < 1 || TOTAL_FOOD > 2047) begin : g_total_food_unsupported
  end

`ifdef FOOD_COUNT_EN
  localparam logic [10:0] c_total = 11'(TOTAL_FOOD);

  logic [10:0] r_eaten_count;
  logic        r_all_eaten;

  // Count each successful eat as its acknowledge is seen; the flag follows the count by a cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_eaten_count <= '0;
      r_all_eaten   <= 1'b0;
    end else begin
      if (r_eat_ack && r_eat_hit && (r_eaten_count < c_total)) begin
        r_eaten_count <= r_eaten_count + 11'd1;
      end
      r_all_eaten <= r_all_eaten || (r_eaten_count == c_total);
    end
  end

  assign bus.eaten_count = r_eaten_count;
  assign bus.all_eaten   = r_all_eaten;
`else
  assign bus.eaten_count = '0;
  assign bus.all_eaten   = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_food_map_arbiter.sv
// ============================================================================
// Module   : tb_food_map_arbiter
// Purpose  : Scoreboard bench for food_map_arbiter. Drivers push expected
//            read rows / eat hits into queues taken from a pellet-matrix
//            model; a monitor pops and compares on rd_valid / eat_ack.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_food_map_arbiter;
  localparam int ROWS  = 60;
  localparam int COLS  = 80;
  localparam int TOTAL = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  food_map_arbiter_if #(.COLS(COLS)) fm();

  food_map_arbiter #(.ROWS(ROWS), .COLS(COLS), .TOTAL_FOOD(TOTAL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (fm)
  );

  // Block RAM model with a back-door load port used only while the arbiter is idle.
  logic [COLS-1:0] mem [64];
  logic            ld_en;
  logic [5:0]      ld_addr;
  logic [COLS-1:0] ld_data;

  always @(posedge clk) begin
    if (ld_en) begin
      mem[ld_addr] = ld_data;
    end else if (fm.bram_en) begin
      fm.bram_dout <= mem[fm.bram_addr];
      if (fm.bram_we) mem[fm.bram_addr] = fm.bram_din;
    end
  end

  // Reference model: the pellet matrix and the number of pellets eaten.
  logic [COLS-1:0] ref_mem [64];
  int              hits;

  logic [COLS-1:0] rd_q  [$];
  bit              eat_q [$];
  int              nvec, nerr;
  int              en_cnt, we_cnt;
  bit              contend;
  int              last_kind;

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    nvec++;
    nerr++;
    $display("FAIL %s: event missing or unexpected", nm);
  endtask

  task automatic load_row(input int row, input logic [COLS-1:0] data);
    ld_en = 1'b1; ld_addr = 6'(row); ld_data = data;
    @(negedge clk);
    ld_en = 1'b0;
    ref_mem[row] = data;
  endtask

  task automatic do_read(input int row, input bit hold);
    int lat, e0, w0;
    rd_q.push_back(ref_mem[row]);
    fm.rd_row = 6'(row); fm.rd_req = 1'b1;
    e0 = en_cnt; w0 = we_cnt; lat = 0;
    do begin @(negedge clk); lat++; end while (!fm.rd_valid && lat < 20);
    if (!fm.rd_valid) fail_now("rd_timeout");
    if (!hold) begin
      fm.rd_req = 1'b0;
      chk("rd_latency", 80'(lat), 80'd3);
      chk("rd_en_cycles", 80'(en_cnt - e0), 80'd1);
      chk("rd_we_cycles", 80'(we_cnt - w0), 80'd0);
    end else begin
      chk("rd_wait_bound", 80'(lat > 7), 80'd0);
    end
  endtask

  task automatic do_eat(input int x, input int y, input bit hold);
    int lat, e0, w0;
    bit in_rng, hit;
    in_rng = (x < COLS) && (y < ROWS);
    hit    = in_rng && ref_mem[y][x];
    if (hit) begin ref_mem[y][x] = 1'b0; hits++; end
    eat_q.push_back(hit);
    fm.eat_x = 7'(x); fm.eat_y = 6'(y); fm.eat_req = 1'b1;
    e0 = en_cnt; w0 = we_cnt; lat = 0;
    do begin @(negedge clk); lat++; end while (!fm.eat_ack && lat < 20);
    if (!fm.eat_ack) fail_now("eat_timeout");
    if (!hold) begin
      fm.eat_req = 1'b0;
      chk("eat_latency", 80'(lat), 80'd4);
      chk("eat_en_cycles", 80'(en_cnt - e0), !in_rng ? 80'd0 : (hit ? 80'd2 : 80'd1));
      chk("eat_we_cycles", 80'(we_cnt - w0), 80'(hit));
    end else begin
      chk("eat_wait_bound", 80'(lat > 7), 80'd0);
    end
  endtask

  task automatic chk_cnt();
    int exp_c, exp_a;
    repeat (3) @(negedge clk);
`ifdef FOOD_COUNT_EN
    exp_c = (hits > TOTAL) ? TOTAL : hits;
    exp_a = (hits >= TOTAL) ? 1 : 0;
`else
    exp_c = 0;
    exp_a = 0;
`endif
    chk("eaten_count", 80'(fm.eaten_count), 80'(exp_c));
    chk("all_eaten", 80'(fm.all_eaten), 80'(exp_a));
  endtask

  task automatic chk_reset_vals();
    chk("rst_rd_valid", 80'(fm.rd_valid), 80'd0);
    chk("rst_eat_ack", 80'(fm.eat_ack), 80'd0);
    chk("rst_eat_hit", 80'(fm.eat_hit), 80'd0);
    chk("rst_bram_en", 80'(fm.bram_en), 80'd0);
    chk("rst_bram_we", 80'(fm.bram_we), 80'd0);
    chk("rst_bram_addr", 80'(fm.bram_addr), 80'd0);
    chk("rst_bram_din", fm.bram_din, 80'd0);
    chk("rst_rd_data", fm.rd_data, 80'd0);
    chk("rst_eaten_count", 80'(fm.eaten_count), 80'd0);
    chk("rst_all_eaten", 80'(fm.all_eaten), 80'd0);
  endtask

  // Abort an eat to a cell holding a pellet, in E_CAP (wr_phase=0) or E_WR (wr_phase=1).
  task automatic reset_mid_eat(input int x, input int y, input bit wr_phase);
    logic [COLS-1:0] row;
    row = ref_mem[y];
    row[x] = 1'b1;
    load_row(y, row);
    fm.eat_x = 7'(x); fm.eat_y = 6'(y); fm.eat_req = 1'b1;
    @(posedge clk);
    @(posedge clk);
    if (wr_phase) begin
      @(posedge clk);
      #2;
      chk("we_before_rst", 80'(fm.bram_we), 80'd1);
    end else begin
      #2;
    end
    rst_n = 1'b0;
    #1;
    chk("we_async_drop", 80'(fm.bram_we), 80'd0);
    chk_reset_vals();
    fm.eat_req = 1'b0;
    hits = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_read(y, 1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    fm.rd_req = 1'b0; fm.rd_row = '0;
    fm.eat_req = 1'b0; fm.eat_x = '0; fm.eat_y = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    nvec = 0; nerr = 0; en_cnt = 0; we_cnt = 0; hits = 0;
    contend = 1'b0; last_kind = -1;

    // Monitor: activity counters and scoreboard comparison on every output strobe.
    fork
      forever begin
        @(negedge clk);
        if (fm.bram_en) en_cnt++;
        if (fm.bram_we) we_cnt++;
        if (fm.rd_valid) begin
          if (rd_q.size() == 0) fail_now("rd_unexpected");
          else chk("rd_data", fm.rd_data, rd_q.pop_front());
          if (contend) chk("grant_alternates", 80'(last_kind == 0), 80'd0);
          last_kind = 0;
        end
        if (fm.eat_ack) begin
          if (eat_q.size() == 0) fail_now("eat_unexpected");
          else chk("eat_hit", 80'(fm.eat_hit), 80'(eat_q.pop_front()));
          if (contend) chk("grant_alternates", 80'(last_kind == 1), 80'd0);
          last_kind = 1;
        end
      end
    join_none

    repeat (2) @(negedge clk);
    chk_reset_vals();
    for (int r = 0; r < 64; r++) load_row(r, {$urandom, $urandom, $urandom});
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    load_row(5, 80'h1);
    load_row(3, '1);
    do_read(5, 1'b0);
    do_eat(10, 3, 1'b0);
    do_read(3, 1'b0);
    do_eat(10, 3, 1'b0);
    do_eat(90, 3, 1'b0);
    do_eat(5, 62, 1'b0);
    chk_cnt();
    do_eat(11, 3, 1'b0);
    chk_cnt();
    do_eat(12, 3, 1'b0);
    chk_cnt();

    // Random single-requester traffic
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) do_read(int'($urandom_range(0, ROWS - 1)), 1'b0);
      else do_eat(int'($urandom_range(0, 95)), int'($urandom_range(0, 63)), 1'b0);
    end
    chk_cnt();

    // Both requesters held continuously; read rows and eat rows are disjoint
    contend = 1'b1;
    last_kind = -1;
    fork
      begin
        for (int i = 0; i < 6; i++) do_read(int'($urandom_range(30, 59)), 1'b1);
        fm.rd_req = 1'b0;
      end
      begin
        for (int j = 0; j < 6; j++) do_eat(int'($urandom_range(0, 79)), int'($urandom_range(0, 29)), 1'b1);
        fm.eat_req = 1'b0;
      end
    join
    contend = 1'b0;
    chk_cnt();

    // Reset in the middle of an eat
    reset_mid_eat(20, 7, 1'b0);
    chk_cnt();
    reset_mid_eat(21, 8, 1'b1);
    do_eat(21, 8, 1'b0);
    chk_cnt();

    repeat (2) @(negedge clk);
    chk("rd_queue_drained", 80'(rd_q.size()), 80'd0);
    chk("eat_queue_drained", 80'(eat_q.size()), 80'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

`default_nettype wire
